// File: rtl/ntt_conf_sequencer_if.sv
// ntt_conf_sequencer_if: control/status bundle between the system controller, the sequencer and top_stage
// Signals:
//   start      controller -> sequencer, one-cycle run request
//   abort      controller -> sequencer, synchronous cancel
//   done_flag  top_stage  -> sequencer, 2'b11 = transform complete
//   conf       sequencer  -> top_stage, configuration code
//   phase      sequencer  -> controller, current phase index (0 when idle)
//   busy       sequencer  -> controller, run in progress
//   done       sequencer  -> controller, one-cycle completion pulse
//   err        sequencer  -> controller, sticky timeout flag
// Modports: slave = sequencer side, master = controller/bench side.
interface ntt_conf_sequencer_if;
    logic       start;
    logic       abort;
    logic [1:0] done_flag;
    logic [3:0] conf;
    logic [2:0] phase;
    logic       busy;
    logic       done;
    logic       err;
    modport master (output start, abort, done_flag, input conf, phase, busy, done, err);
    modport slave (input start, abort, done_flag, output conf, phase, busy, done, err);
endinterface

// File: rtl/ntt_conf_sequencer.sv
// ntt_conf_sequencer: steps the 512-point NTT datapath through its 8-phase conf schedule from one start request
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  ntt_conf_sequencer_if.slave (start/abort/done_flag in; conf/phase/busy/done/err out)
// Optional: define NTT_SEQ_EARLY_ADV_EN to let a done_flag[0] rising edge end long phases (p2, p4) early.
module ntt_conf_sequencer #(
    parameter int SHORT_LEN = 128,
    parameter int GAP_LEN   = 16,
    parameter int LONG_LEN  = 512,
    parameter int CNT_W     = 10,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    ntt_conf_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_FIN, DONE} state_t;
    state_t            state, state_nx;
    logic [2:0]        ph, ph_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              err_q, err_nx;
    logic [CNT_W-1:0]  last;
    logic [3:0]        conf_run;
    logic              early;
    // terminal count of the current RUN phase
    always_comb begin
        last = (ph == 3'd2 || ph == 3'd4) ? CNT_W'(LONG_LEN - 1) :
               (ph == 3'd0 || ph == 3'd6) ? CNT_W'(SHORT_LEN - 1) : CNT_W'(GAP_LEN - 1);
    end
    always_comb begin
        conf_run = 4'd0;
        case (ph)
            3'd0: conf_run = 4'd1;
            3'd1: conf_run = 4'd3;
            3'd2: conf_run = 4'd2;
            3'd3: conf_run = 4'd4;
            3'd4: conf_run = 4'd6;
            3'd5: conf_run = 4'd8;
            3'd6: conf_run = 4'd5;
            default: conf_run = 4'd7;
        endcase
    end
`ifdef NTT_SEQ_EARLY_ADV_EN
    logic flag_prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flag_prev <= 1'b0;
        else flag_prev <= bus.done_flag[0];
    end
    // rising edge of done_flag[0] cuts a long compute phase short
    assign early = (ph == 3'd2 || ph == 3'd4) && bus.done_flag[0] && !flag_prev;
`else
    assign early = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ph    <= 3'd0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end
    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        cnt_nx   = cnt;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                // abort arriving with start drops the request
                if (bus.start && !bus.abort) begin
                    state_nx = RUN;
                    ph_nx    = 3'd0;
                    cnt_nx   = '0;
                    err_nx   = 1'b0;
                end
            end
            RUN: begin
                if (cnt == last || early) begin
                    cnt_nx   = '0;
                    ph_nx    = ph + 3'd1;
                    state_nx = (ph == 3'd6) ? WAIT_FIN : RUN;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WAIT_FIN: begin
                // completion wins over a timeout landing in the same cycle
                if (bus.done_flag == 2'b11) begin
                    state_nx = DONE;
                    ph_nx    = 3'd0;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = IDLE;
                    ph_nx    = 3'd0;
                    cnt_nx   = '0;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                ph_nx    = 3'd0;
                cnt_nx   = '0;
            end
        endcase
        if (state != IDLE && bus.abort) begin
            state_nx = IDLE;
            ph_nx    = 3'd0;
            cnt_nx   = '0;
        end
    end
    // outputs decode the registered state, so conf changes exactly on the phase edge
    assign bus.conf  = (state == RUN) ? conf_run : (state == WAIT_FIN) ? 4'd7 : 4'd0;
    assign bus.phase = ph;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.err   = err_q;
endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// tb_ntt_conf_sequencer: randomized directed checks of the conf schedule against a phase-table model
module tb_ntt_conf_sequencer;
    localparam int TIMEOUT = 1023;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int confs[8] = '{1, 3, 2, 4, 6, 8, 5, 7};
    int lens[7] = '{128, 16, 512, 16, 512, 16, 128};
    ntt_conf_sequencer_if bus();
    ntt_conf_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic int ph_of(int t, int l2);
        for (int i = 0; i < 7; i++) begin
            int l = (i == 2) ? l2 : lens[i];
            if (t < l) return i;
            t -= l;
        end
        return 7;
    endfunction
    task automatic idle_chk(input string tag);
        chk({tag, "_conf"}, bus.conf, 0);
        chk({tag, "_phase"}, bus.phase, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask
    // w>0: done_flag=11 in the w-th WAIT_FIN cycle; w==0: let it time out. -1 disables an event.
    task automatic run(input int w, input int l2, input int abort_at, input int start_at,
                       input int rise_at, input int rst_at);
        int n = 0;
        int p;
        for (int i = 0; i < 7; i++) n += (i == 2) ? l2 : lens[i];
        bus.start = 1'b1;
        chk("start_cycle_conf", bus.conf, 0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; ; t++) begin
            if (t > 5000) begin
                chk("cycle_budget", t, 0);
                return;
            end
            p = ph_of(t, l2);
            chk("run_conf", bus.conf, confs[p]);
            chk("run_phase", bus.phase, p);
            chk("run_busy", bus.busy, 1);
            chk("run_done", bus.done, 0);
            chk("run_err", bus.err, 0);
            if (t == abort_at) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                idle_chk("abort");
                return;
            end
            if (t == rst_at) begin
                #2 rst = 1'b0;
                #1 idle_chk("async_rst");
                chk("async_rst_err", bus.err, 0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            bus.start = (t == start_at);
            if (t == rise_at) bus.done_flag = 2'b01;
            if (w == 0 && t == n + TIMEOUT - 1) begin
                @(negedge clk);
                idle_chk("timeout");
                chk("timeout_err", bus.err, 1);
                bus.done_flag = 2'b00;
                return;
            end
            if (w > 0 && t == n + w - 1) begin
                bus.done_flag = 2'b11;
                @(negedge clk);
                bus.done_flag = 2'b00;
                chk("done_conf", bus.conf, 0);
                chk("done_pulse", bus.done, 1);
                chk("done_busy", bus.busy, 1);
                chk("done_phase", bus.phase, 0);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                idle_chk("after_done");
                return;
            end
            @(negedge clk);
        end
    endtask
    initial begin
        int l2;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.done_flag = 2'b00;
        #2 idle_chk("reset");
        chk("reset_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idle_chk("post_reset");
        run(5, 512, -1, -1, -1, -1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        idle_chk("start_abort_idle");
        run($urandom_range(1, 30), 512, $urandom_range(150, 650), -1, -1, -1);
        run($urandom_range(1, 30), 512, -1, $urandom_range(672, 1183), -1, -1);
        run(0, 512, -1, -1, -1, -1);
        chk("err_sticky", bus.err, 1);
        run($urandom_range(1, 30), 512, -1, -1, -1, $urandom_range(1184, 1199));
        idle_chk("after_rst");
`ifdef NTT_SEQ_EARLY_ADV_EN
        l2 = 201;
`else
        l2 = 512;
`endif
        run($urandom_range(1, 30), l2, -1, -1, 144 + 200, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
